// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam int unsigned LEN_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = WORD_BYTES * BYTE_W;
    localparam int unsigned LEN_W      = LEN_BYTES * BYTE_W;

endpackage

// File: rtl/word_packer.sv
// Assembles little-endian 32-bit words from a byte stream; flags the byte completing each word.
module word_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_c,
    output logic              word_done_c
);

    localparam int unsigned IDX_W   = $clog2(WORD_BYTES);
    localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

    logic [IDX_W-1:0]   byte_idx;
    logic [SHIFT_W-1:0] shift;

    // First three bytes sit in shift; the fourth arrives live on byte_in.
    assign word_c      = {byte_in, shift};
    assign word_done_c = byte_valid && (byte_idx == IDX_W'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_idx <= '0;
            shift    <= '0;
        end else if (byte_valid) begin
            byte_idx <= byte_idx + IDX_W'(1);
            shift    <= {byte_in, shift[SHIFT_W-1:BYTE_W]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/checksum frame, writes instruction memory,
// and releases the core from reset only after a clean load.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(1) << ADDR_W;

    state_t              state;
    logic [LEN_W-1:0]    count;
    logic [IDX_W-1:0]    word_idx;
    logic [BYTE_W-1:0]   csum;
    logic [LEN_W-1:0]    len_full;
    logic                accept;
    logic                data_byte;
    logic                last_word;
    logic [WORD_W-1:0]   word_c;
    logic                word_done_c;

    assign in_ready  = (state inside {LEN_LO, LEN_HI, DATA, CHECK}) && !load_req;
    assign accept    = in_valid && in_ready;
    assign data_byte = accept && (state == DATA);
    assign len_full  = {in_data, count[BYTE_W-1:0]};
    assign last_word = (CNT_W'(word_idx) + CNT_W'(1)) == CNT_W'(count);

    word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (load_req),
        .byte_valid  (data_byte),
        .byte_in     (in_data),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

    // Frame FSM with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LEN_LO;
            count      <= '0;
            word_idx   <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else if (load_req) begin
            state      <= LEN_LO;
            word_idx   <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (word_done_c) begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx[ADDR_W-1:0];
                imem_wdata <= word_c;
                word_idx   <= word_idx + IDX_W'(1);
            end
            if (accept) begin
                case (state)
                    LEN_LO: begin
                        count[BYTE_W-1:0] <= in_data;
                        state             <= LEN_HI;
                    end
                    LEN_HI: begin
                        count[LEN_W-1:BYTE_W] <= in_data;
                        if (CNT_W'(len_full) > CAPACITY) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else if (len_full == '0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        csum <= csum ^ in_data;
                        if (word_done_c && last_word) begin
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (in_data == csum) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
